pr_bridge: RTL and testbench
============================

Name: pr_bridge

Overview:
- Bridge between the multi-cycle CPU's processor bus (PrAddr/PrWe/BE/PrDOut/PrDIn) and two memory-mapped peripherals.
- Decodes the address and sequences each access with a request/ready handshake, including device wait-states and a timeout.
- Returns read data or a bus error to the CPU.
- Registers the peripheral interrupt lines onto the CPU's HWInt[7:2] vector.

Parameters:
- DEV0_BASE, 30'h1FC0, word address of the device-0 window (byte 0x0000_7F00).
- DEV1_BASE, 30'h1FC4, word address of the device-1 window (byte 0x0000_7F10).
- DEV_WORDS, 4, words per device window; must be a power of two.
- TIMEOUT, 15, maximum ACCESS cycles before a bus error; must be at least 1.

Ports:
- clk  in  1  clock (one clock domain).
- rst  in  1  asynchronous, active-low reset.
- PrReq  in  1  CPU access request; held stable with address/data until PrRdy.
- PrAddr  in  [31:2]  CPU word address.
- PrWe  in  1  1 = write, 0 = read.
- BE  in  4  byte enables.
- PrDOut  in  32  CPU write data.
- PrDIn  out  32  read data to the CPU; valid while PrRdy=1.
- PrRdy  out  1  access complete; one-cycle pulse.
- PrErr  out  1  bus error; valid while PrRdy=1.
- DEV_Addr  out  2  word offset inside the selected window (PrAddr[3:2]).
- DEV_WD  out  32  latched write data.
- DEV_BE  out  4  latched byte enables.
- DEV_We  out  1  write strobe; held through ACCESS.
- DEV0_Sel  out  1  device-0 select.
- DEV1_Sel  out  1  device-1 select.
- DEV0_Rdy  in  1  device-0 done.
- DEV1_Rdy  in  1  device-1 done.
- DEV0_RD  in  32  device-0 read data.
- DEV1_RD  in  32  device-1 read data.
- DEV0_Irq  in  1  device-0 interrupt request (level).
- DEV1_Irq  in  1  device-1 interrupt request (level).
- HWInt  out  [7:2]  interrupt vector to the CPU.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE immediately.
  - All outputs drive 0: PrRdy, PrErr, PrDIn, DEV*_Sel, DEV_We, DEV_Addr, DEV_WD, DEV_BE, HWInt.
  - The timeout counter clears.
  - Reset in the middle of an access abandons it; no completion is reported.
- All outputs are registered.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - PrReq=1 with a hit (address inside a window and BE!=0):
    - latch DEV_Addr, DEV_WD, DEV_BE, DEV_We=PrWe;
    - set the matching DEV*_Sel;
    - clear the counter; next state ACCESS.
  - PrReq=1 with a miss, or BE=0: next state DONE with PrErr=1, PrDIn=0, no select asserted.
  - PrReq=0: stay in IDLE.
- ACCESS:
  - Select and latched outputs are held stable.
  - Selected DEV*_Rdy=1: capture the selected DEV*_RD into PrDIn (0 for writes), PrErr=0, go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no Rdy, go to DONE with PrErr=1 and PrDIn=0. ACCESS therefore lasts at most TIMEOUT cycles.
  - Rdy and timeout in the same cycle: Rdy wins (successful completion).
  - Rdy from the non-selected device is ignored.
- Leaving ACCESS: Sel and DEV_We deassert on the same edge that enters DONE.
- Write commit: a device commits a write on the rising edge at which it drives Rdy=1. A timed-out write is not committed.
- DONE:
  - PrRdy=1 for exactly one cycle; then unconditionally IDLE.
  - The CPU drops PrReq after sampling PrRdy. A PrReq seen in IDLE afterwards is a new access.
- Latency (request sampled in IDLE at edge 0):
  - hit with immediate Rdy: PrRdy high in cycle 2;
  - hit with n wait cycles: cycle 2+n;
  - miss: cycle 1.
- PrDIn and PrErr hold their values after the PrRdy pulse until the next DONE.
- Interrupts:
  - HWInt[2] <= DEV0_Irq and HWInt[3] <= DEV1_Irq, registered with one-cycle latency.
  - HWInt[7:4] = 0.
- Counter width: $clog2(TIMEOUT)+1 bits; it never wraps.

Decomposition:
- Shared package:
  - state encodings S_IDLE=2'd0, S_ACCESS=2'd1, S_DONE=2'd2;
  - DEV0_BASE/DEV1_BASE defaults;
  - HWInt bit indices for DEV0/DEV1.
- One combinational sub-module, pr_addr_dec: PrAddr and BE in; hit0, hit1, miss out.

Test Plan:
- Read hit, no wait: PrReq with PrAddr = byte 0x7F04, PrWe=0, DEV0_Rdy tied 1, DEV0_RD=32'hDEADBEEF -> DEV0_Sel high exactly 1 cycle, DEV_Addr=2'b01, PrRdy pulse in cycle 2, PrDIn=32'hDEADBEEF, PrErr=0.
- Write with wait states: write of 32'h12345678 to byte 0x7F18, BE=4'hF, DEV1_Rdy after 3 cycles -> DEV1_Sel and DEV_We high for 4 cycles, DEV_WD=32'h12345678, PrRdy in cycle 5, PrErr=0.
- Miss: PrAddr = byte 0x0000_1000 -> no Sel, PrRdy in cycle 1, PrErr=1, PrDIn=0. A BE=0 request to 0x7F00 gives the same response.
- Timeout boundary:
  - Rdy never asserted -> Sel high for exactly 15 cycles, then PrRdy with PrErr=1.
  - Rdy asserted in the 15th ACCESS cycle -> success, PrErr=0.
- Reset mid-access: rst pulled low during ACCESS -> Sel, DEV_We and PrRdy go 0 without waiting for a clock edge. After release a new request completes normally.
- Interrupts: DEV0_Irq=1, then DEV1_Irq=1 -> HWInt=6'b000001, then 6'b000011, each one cycle after its input. HWInt[7:4] stays 0.

Source files
------------

// File: rtl/pr_bridge_pkg.sv
// Shared definitions for the processor-bus bridge: FSM encoding, default
// device windows and interrupt-vector bit positions.
package pr_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [29:0] DEV0_BASE_DEF = 30'h1FC0;
  localparam logic [29:0] DEV1_BASE_DEF = 30'h1FC4;

  // Absolute bit positions inside HWInt[7:2].
  localparam int HWINT_DEV0 = 2;
  localparam int HWINT_DEV1 = 3;

endpackage

// File: rtl/pr_addr_dec.sv
// Combinational window decode of a CPU word address; an all-zero byte
// enable never counts as a hit.
module pr_addr_dec
  import pr_bridge_pkg::*;
#(
  parameter logic [29:0] DEV0_BASE = DEV0_BASE_DEF,
  parameter logic [29:0] DEV1_BASE = DEV1_BASE_DEF,
  parameter int          DEV_WORDS = 4
) (
  input  logic [31:2] PrAddr,
  input  logic [3:0]  BE,
  output logic        hit0,
  output logic        hit1,
  output logic        miss
);

  localparam logic [29:0] WIN_MASK = ~30'(DEV_WORDS - 1);

  logic beAny;

  always_comb begin
    beAny = (BE != 4'b0000);
    hit0  = beAny && ((PrAddr & WIN_MASK) == DEV0_BASE);
    hit1  = beAny && ((PrAddr & WIN_MASK) == DEV1_BASE);
    miss  = !(hit0 || hit1);
  end

endmodule

// File: rtl/pr_bridge.sv
// Processor-bus bridge: decodes CPU accesses onto two peripherals with a
// ready handshake and timeout, and registers the peripheral interrupts.
module pr_bridge
  import pr_bridge_pkg::*;
#(
  parameter logic [29:0] DEV0_BASE = DEV0_BASE_DEF,
  parameter logic [29:0] DEV1_BASE = DEV1_BASE_DEF,
  parameter int          DEV_WORDS = 4,
  parameter int          TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PrReq,
  input  logic [31:2] PrAddr,
  input  logic        PrWe,
  input  logic [3:0]  BE,
  input  logic [31:0] PrDOut,
  output logic [31:0] PrDIn,
  output logic        PrRdy,
  output logic        PrErr,
  output logic [1:0]  DEV_Addr,
  output logic [31:0] DEV_WD,
  output logic [3:0]  DEV_BE,
  output logic        DEV_We,
  output logic        DEV0_Sel,
  output logic        DEV1_Sel,
  input  logic        DEV0_Rdy,
  input  logic        DEV1_Rdy,
  input  logic [31:0] DEV0_RD,
  input  logic [31:0] DEV1_RD,
  input  logic        DEV0_Irq,
  input  logic        DEV1_Irq,
  output logic [7:2]  HWInt,
  output logic [1:0]  dbgState
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  // Handshake: PrReq with address/data is held until the one-cycle PrRdy
  // pulse; a selected device finishes by raising its Rdy while selected.
  state_t        state;
  logic [CW-1:0] cnt;
  logic          hit0, hit1, miss;
  logic          selRdy;
  logic [31:0]   selRd;

  pr_addr_dec #(
    .DEV0_BASE (DEV0_BASE),
    .DEV1_BASE (DEV1_BASE),
    .DEV_WORDS (DEV_WORDS)
  ) u_dec (
    .PrAddr (PrAddr),
    .BE     (BE),
    .hit0   (hit0),
    .hit1   (hit1),
    .miss   (miss)
  );

  always_comb begin
    selRdy = (DEV0_Sel && DEV0_Rdy) || (DEV1_Sel && DEV1_Rdy);
    selRd  = DEV0_Sel ? DEV0_RD : DEV1_RD;
  end

  assign dbgState = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      PrDIn    <= '0;
      PrRdy    <= 1'b0;
      PrErr    <= 1'b0;
      DEV_Addr <= '0;
      DEV_WD   <= '0;
      DEV_BE   <= '0;
      DEV_We   <= 1'b0;
      DEV0_Sel <= 1'b0;
      DEV1_Sel <= 1'b0;
      HWInt    <= '0;
    end else begin
      PrRdy             <= 1'b0;
      HWInt             <= '0;
      HWInt[HWINT_DEV0] <= DEV0_Irq;
      HWInt[HWINT_DEV1] <= DEV1_Irq;
      case (state)
        S_IDLE: begin
          if (PrReq) begin
            if (miss) begin
              PrErr <= 1'b1;
              PrDIn <= '0;
              PrRdy <= 1'b1;
              state <= S_DONE;
            end else begin
              DEV_Addr <= PrAddr[3:2];
              DEV_WD   <= PrDOut;
              DEV_BE   <= BE;
              DEV_We   <= PrWe;
              DEV0_Sel <= hit0;
              DEV1_Sel <= hit1;
              cnt      <= '0;
              state    <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          // Ready is checked before the timeout so a last-cycle Rdy succeeds.
          if (selRdy) begin
            PrDIn    <= DEV_We ? 32'h0 : selRd;
            PrErr    <= 1'b0;
            PrRdy    <= 1'b1;
            DEV0_Sel <= 1'b0;
            DEV1_Sel <= 1'b0;
            DEV_We   <= 1'b0;
            state    <= S_DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            PrDIn    <= '0;
            PrErr    <= 1'b1;
            PrRdy    <= 1'b1;
            DEV0_Sel <= 1'b0;
            DEV1_Sel <= 1'b0;
            DEV_We   <= 1'b0;
            state    <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pr_bridge.sv
// Directed bench for pr_bridge: hit/miss/wait-state/timeout/reset/interrupt
// scenarios with hand-computed expectations.
module tb_pr_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        PrReq;
  logic [31:2] PrAddr;
  logic        PrWe;
  logic [3:0]  BE;
  logic [31:0] PrDOut;
  logic [31:0] PrDIn;
  logic        PrRdy;
  logic        PrErr;
  logic [1:0]  DEV_Addr;
  logic [31:0] DEV_WD;
  logic [3:0]  DEV_BE;
  logic        DEV_We;
  logic        DEV0_Sel;
  logic        DEV1_Sel;
  logic        DEV0_Rdy;
  logic        DEV1_Rdy;
  logic [31:0] DEV0_RD;
  logic [31:0] DEV1_RD;
  logic        DEV0_Irq;
  logic        DEV1_Irq;
  logic [7:2]  HWInt;
  logic [1:0]  dbgState;

  int total = 0;
  int bad   = 0;
  int selC, weC, rdyC;

  pr_bridge dut (
    .clk      (clk),
    .rst      (rst),
    .PrReq    (PrReq),
    .PrAddr   (PrAddr),
    .PrWe     (PrWe),
    .BE       (BE),
    .PrDOut   (PrDOut),
    .PrDIn    (PrDIn),
    .PrRdy    (PrRdy),
    .PrErr    (PrErr),
    .DEV_Addr (DEV_Addr),
    .DEV_WD   (DEV_WD),
    .DEV_BE   (DEV_BE),
    .DEV_We   (DEV_We),
    .DEV0_Sel (DEV0_Sel),
    .DEV1_Sel (DEV1_Sel),
    .DEV0_Rdy (DEV0_Rdy),
    .DEV1_Rdy (DEV1_Rdy),
    .DEV0_RD  (DEV0_RD),
    .DEV1_RD  (DEV1_RD),
    .DEV0_Irq (DEV0_Irq),
    .DEV1_Irq (DEV1_Irq),
    .HWInt    (HWInt),
    .dbgState (dbgState)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. waitN<0 means the device never answers; noise drives
  // the non-selected device's Rdy high throughout.
  task automatic do_access(input logic we, input logic [29:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input int waitN, input logic noise,
                           output int selCyc, output int weCyc, output int rdyCyc);
    int selCnt;
    selCyc = 0; weCyc = 0; rdyCyc = 0; selCnt = 0;
    PrReq = 1'b1; PrWe = we; PrAddr = addr; BE = be; PrDOut = wd;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (DEV0_Sel || DEV1_Sel) begin selCyc++; selCnt++; end
      if (DEV_We) weCyc++;
      if (PrRdy) begin rdyCyc = c; break; end
      DEV0_Rdy = noise & DEV1_Sel;
      DEV1_Rdy = noise & DEV0_Sel;
      if (waitN >= 0 && selCnt == waitN + 1) begin
        if (DEV0_Sel) DEV0_Rdy = 1'b1;
        if (DEV1_Sel) DEV1_Rdy = 1'b1;
      end
    end
    PrReq = 1'b0; DEV0_Rdy = 1'b0; DEV1_Rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b0; PrReq = 1'b0; PrAddr = '0; PrWe = 1'b0; BE = 4'h0; PrDOut = '0;
    DEV0_Rdy = 1'b0; DEV1_Rdy = 1'b0; DEV0_RD = '0; DEV1_RD = '0;
    DEV0_Irq = 1'b0; DEV1_Irq = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_prrdy", PrRdy, 0);
    chk("rst_sel", {DEV0_Sel, DEV1_Sel, DEV_We}, 0);
    chk("rst_prdin", PrDIn, 0);
    chk("rst_hwint", HWInt, 0);
    chk("rst_state", dbgState, 0);
    rst = 1'b1;
    @(negedge clk);

    // Read hit on byte 0x7F04, no wait states.
    DEV0_RD = 32'hDEADBEEF;
    do_access(1'b0, 30'h1FC1, 4'hF, 32'h0, 0, 1'b0, selC, weC, rdyC);
    chk("rd_rdy_cyc", rdyC, 2);
    chk("rd_sel_cyc", selC, 1);
    chk("rd_prdin", PrDIn, 32'hDEADBEEF);
    chk("rd_prerr", PrErr, 0);
    chk("rd_devaddr", DEV_Addr, 2'b01);
    chk("rd_sel_off", {DEV0_Sel, DEV1_Sel}, 0);
    @(negedge clk);
    chk("rd_pulse_end", PrRdy, 0);
    chk("rd_prdin_hold", PrDIn, 32'hDEADBEEF);

    // Write to byte 0x7F18 with 3 wait states.
    do_access(1'b1, 30'h1FC6, 4'hF, 32'h12345678, 3, 1'b0, selC, weC, rdyC);
    chk("wr_rdy_cyc", rdyC, 5);
    chk("wr_sel_cyc", selC, 4);
    chk("wr_we_cyc", weC, 4);
    chk("wr_wd", DEV_WD, 32'h12345678);
    chk("wr_be", DEV_BE, 4'hF);
    chk("wr_devaddr", DEV_Addr, 2'b10);
    chk("wr_prerr", PrErr, 0);
    chk("wr_prdin", PrDIn, 0);
    @(negedge clk);

    // Miss at byte 0x1000.
    do_access(1'b0, 30'h0400, 4'hF, 32'h0, 0, 1'b0, selC, weC, rdyC);
    chk("miss_rdy_cyc", rdyC, 1);
    chk("miss_sel_cyc", selC, 0);
    chk("miss_prerr", PrErr, 1);
    chk("miss_prdin", PrDIn, 0);
    @(negedge clk);

    // BE=0 to 0x7F00 behaves as a miss.
    do_access(1'b0, 30'h1FC0, 4'h0, 32'h0, 0, 1'b0, selC, weC, rdyC);
    chk("be0_rdy_cyc", rdyC, 1);
    chk("be0_sel_cyc", selC, 0);
    chk("be0_prerr", PrErr, 1);
    @(negedge clk);

    // Timeout: DEV1 never answers while DEV0 Rdy toggles high as noise.
    DEV1_RD = 32'hCAFEF00D;
    do_access(1'b0, 30'h1FC5, 4'hF, 32'h0, -1, 1'b1, selC, weC, rdyC);
    chk("to_sel_cyc", selC, 15);
    chk("to_rdy_cyc", rdyC, 16);
    chk("to_prerr", PrErr, 1);
    chk("to_prdin", PrDIn, 0);
    @(negedge clk);

    // Rdy in the 15th ACCESS cycle still succeeds.
    do_access(1'b0, 30'h1FC7, 4'hF, 32'h0, 14, 1'b0, selC, weC, rdyC);
    chk("lastrdy_sel_cyc", selC, 15);
    chk("lastrdy_rdy_cyc", rdyC, 16);
    chk("lastrdy_prerr", PrErr, 0);
    chk("lastrdy_prdin", PrDIn, 32'hCAFEF00D);
    @(negedge clk);

    // Asynchronous reset in the middle of a write access.
    PrReq = 1'b1; PrWe = 1'b1; PrAddr = 30'h1FC2; BE = 4'h3; PrDOut = 32'hA5A5A5A5;
    repeat (3) @(negedge clk);
    chk("mid_sel_on", {DEV0_Sel, DEV_We}, 2'b11);
    #2 rst = 1'b0;
    #1;
    chk("mid_sel_off", {DEV0_Sel, DEV1_Sel, DEV_We}, 0);
    chk("mid_prrdy", PrRdy, 0);
    chk("mid_state", dbgState, 0);
    PrReq = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", PrRdy, 0);
    DEV0_RD = 32'h0BADC0DE;
    do_access(1'b0, 30'h1FC3, 4'hF, 32'h0, 1, 1'b0, selC, weC, rdyC);
    chk("post_rdy_cyc", rdyC, 3);
    chk("post_prdin", PrDIn, 32'h0BADC0DE);
    chk("post_prerr", PrErr, 0);
    @(negedge clk);

    // Interrupt registration.
    DEV0_Irq = 1'b1;
    chk("irq_before", HWInt, 6'b000000);
    @(negedge clk);
    chk("irq0", HWInt, 6'b000001);
    DEV1_Irq = 1'b1;
    @(negedge clk);
    chk("irq01", HWInt, 6'b000011);
    DEV0_Irq = 1'b0;
    @(negedge clk);
    chk("irq1", HWInt, 6'b000010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
